spi_reg_ctrl: RTL

//  Command sequencer behind the SPI slave byte engine; turns a CS frame into register-bus accesses.

---
 rtl/spi_reg_pkg.sv | 29 ++
 rtl/spi_reg_ctrl_sync.sv | 27 ++
 rtl/spi_reg_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register-access sequencer: FSM encodings, command layout, idle bytes.
package spi_reg_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_CMD     = 3'd1;
    localparam logic [STATE_W-1:0] ST_WR      = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_REQ  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD_CAP  = 3'd4;
    localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd5;
    localparam logic [STATE_W-1:0] ST_DISCARD = 3'd6;

    localparam int unsigned         CMD_RW_BIT     = 7;
    localparam logic [BYTE_W-1:0]   TX_IDLE_BYTE   = 8'h00;
    localparam logic [BYTE_W-1:0]   STATUS_DEFAULT = 8'hA5;

    // True when command address bits above the implemented width are all zero.
    function automatic logic cmd_addr_ok(input logic [BYTE_W-1:0] cmd, input int unsigned addr_w);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < CMD_RW_BIT; i++) begin
            if (i >= addr_w && cmd[i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module spi_reg_ctrl_sync #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame to register-bus command sequencer.
// Build option: SPI_REG_CTRL_AUTOINC_EN enables address auto-increment after each data byte.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned        ADDR_W = 4,
    parameter logic [BYTE_W-1:0]  STATUS = STATUS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS_i,
    input  logic [BYTE_W-1:0] RxData_i,
    input  logic              RxDone_i,
    output logic [BYTE_W-1:0] TxData_o,
    output logic [ADDR_W-1:0] RegAddr_o,
    output logic [BYTE_W-1:0] RegWrData_o,
    output logic              RegWrite_o,
    output logic              RegRead_o,
    input  logic [BYTE_W-1:0] RegRdData_i,
    output logic              Busy_o,
    output logic              Error_o
);

    logic                cs_sync;
    logic                cs_prev_q;
    logic                cs_rise_c;
    logic                cs_fall_c;
    logic                cmd_ok_c;
    logic [ADDR_W-1:0]   addr_inc_c;

    logic [STATE_W-1:0]  state_q,  state_d;
    logic [BYTE_W-1:0]   tx_q,     tx_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [BYTE_W-1:0]   wrdata_q, wrdata_d;
    logic                write_q,  write_d;
    logic                read_q,   read_d;
    logic                error_q,  error_d;
    logic                busy_q,   busy_d;

    spi_reg_ctrl_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (CS_i),
        .q_o   (cs_sync)
    );

    assign cs_rise_c = cs_sync & ~cs_prev_q;
    assign cs_fall_c = ~cs_sync & cs_prev_q;
    assign cmd_ok_c  = cmd_addr_ok(RxData_i, ADDR_W);

`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign addr_inc_c = addr_q + ADDR_W'(1);
`else
    assign addr_inc_c = addr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            tx_q      <= STATUS;
            addr_q    <= '0;
            wrdata_q  <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cs_prev_q <= cs_sync;
            state_q   <= state_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
            write_q   <= write_d;
            read_q    <= read_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    // Next state; CS edges override whatever the current state wants.
    always_comb begin
        state_d = state_q;
        if (cs_rise_c) begin
            state_d = ST_IDLE;
        end else if (cs_fall_c) begin
            state_d = ST_CMD;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (RxDone_i) begin
                        if (!cmd_ok_c)                 state_d = ST_DISCARD;
                        else if (RxData_i[CMD_RW_BIT]) state_d = ST_RD_REQ;
                        else                           state_d = ST_WR;
                    end
                end
                ST_RD_REQ:  state_d = ST_RD_CAP;
                // First RD_CAP cycle carries the read strobe; data is captured on the second.
                ST_RD_CAP:  if (!read_q) state_d = ST_RD_WAIT;
                ST_RD_WAIT: if (RxDone_i) state_d = ST_RD_REQ;
                ST_IDLE, ST_WR, ST_DISCARD: state_d = state_q;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and strobes.
    always_comb begin
        tx_d     = tx_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        write_d  = 1'b0;
        read_d   = 1'b0;
        error_d  = 1'b0;
        busy_d   = busy_q;

        // Advance only after the write strobe has been presented at the current address.
        if (write_q) addr_d = addr_inc_c;

        if (cs_rise_c || cs_fall_c) begin
            tx_d   = STATUS;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (RxDone_i) begin
                        addr_d = RxData_i[ADDR_W-1:0];
                        if (!cmd_ok_c) begin
                            error_d = 1'b1;
                            tx_d    = TX_IDLE_BYTE;
                        end else begin
                            busy_d = 1'b1;
                            if (!RxData_i[CMD_RW_BIT]) tx_d = TX_IDLE_BYTE;
                        end
                    end
                end
                ST_WR: begin
                    if (RxDone_i) begin
                        wrdata_d = RxData_i;
                        write_d  = 1'b1;
                        tx_d     = TX_IDLE_BYTE;
                    end
                end
                ST_RD_REQ: read_d = 1'b1;
                ST_RD_CAP: begin
                    if (!read_q) begin
                        tx_d   = RegRdData_i;
                        addr_d = addr_inc_c;
                    end
                end
                ST_DISCARD: tx_d = TX_IDLE_BYTE;
                default: ;
            endcase
        end
    end

    assign TxData_o    = tx_q;
    assign RegAddr_o   = addr_q;
    assign RegWrData_o = wrdata_q;
    assign RegWrite_o  = write_q;
    assign RegRead_o   = read_q;
    assign Error_o     = error_q;
    assign Busy_o      = busy_q;

endmodule
